// File: rtl/mult_job_sched_pkg.sv
// Shared definitions for the two-port multiply job scheduler: state codes,
// address width default and multiplier latency bounds.
package mult_job_sched_pkg;

  localparam int ADDR_W_DEF  = 3;
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  // State codes double as the st_out debug value.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_MULT   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Out-of-range latencies are clamped so the MULT counter always fits.
  function automatic logic [CNT_W-1:0] mult_cnt_init(int lat);
    int l;
    l = lat;
    if (l < MUL_LAT_MIN) l = MUL_LAT_MIN;
    if (l > MUL_LAT_MAX) l = MUL_LAT_MAX;
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/mult_job_sched_if.sv
// Job request / datapath control bundle between requesters and the scheduler.
interface mult_job_sched_if #(
  parameter int ADDR_W = mult_job_sched_pkg::ADDR_W_DEF
);

  logic [1:0]          req;
  logic [2*ADDR_W-1:0] src_a;
  logic [2*ADDR_W-1:0] src_b;
  logic [2*ADDR_W-1:0] dst;
  logic [1:0]          grant;
  logic [1:0]          done;
  logic                busy;
  logic [ADDR_W-1:0]   rf_adr;
  logic                ld_a;
  logic                ld_b;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_adr;
  logic [2:0]          st_out;

  modport master (
    output req, src_a, src_b, dst,
    input  grant, done, busy, rf_adr, ld_a, ld_b, ram_we, ram_adr, st_out
  );

  modport slave (
    input  req, src_a, src_b, dst,
    output grant, done, busy, rf_adr, ld_a, ld_b, ram_we, ram_adr, st_out
  );

endinterface

// File: rtl/mult_job_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers who was granted
// last so a tie goes to the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  assign last_d = adv_i ? gnt_o[1] : last_q;

  // Reset value 1 means "requester 1 went last", so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mult_job_sched.sv
// Shares the register-file / multiplier / RAM datapath between two requesters,
// sequencing operand loads, multiply wait and result write per granted job.
module mult_job_sched
  import mult_job_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  mult_job_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = mult_cnt_init(MUL_LAT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  a_q, b_q, dst_q;
  logic               id_q;
  logic [1:0]         arb_gnt;
  logic               take;
  logic               win;

  assign take = (state_q == S_IDLE) && (|bus.req) && !reset;
  assign win  = arb_gnt[1];

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (bus.req),
    .adv_i (take),
    .gnt_o (arb_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Job fields are frozen at grant; they need no reset since every output
  // that exposes them is qualified by state.
  always_ff @(posedge clk) begin
    if (take) begin
      a_q   <= bus.src_a[win*ADDR_W +: ADDR_W];
      b_q   <= bus.src_b[win*ADDR_W +: ADDR_W];
      dst_q <= bus.dst[win*ADDR_W +: ADDR_W];
      id_q  <= win;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus.grant   = 2'b00;
    bus.done    = 2'b00;
    bus.busy    = 1'b1;
    bus.rf_adr  = '0;
    bus.ld_a    = 1'b0;
    bus.ld_b    = 1'b0;
    bus.ram_we  = 1'b0;
    bus.ram_adr = '0;
    bus.st_out  = state_q;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (take) begin
          bus.grant = arb_gnt;
          state_d   = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        bus.rf_adr = a_q;
        bus.ld_a   = 1'b1;
        state_d    = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus.rf_adr = b_q;
        bus.ld_b   = 1'b1;
        cnt_d      = CNT_INIT;
        state_d    = S_MULT;
      end
      S_MULT: begin
        if (cnt_q == '0) state_d = S_WRITE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WRITE: begin
        bus.ram_adr = dst_q;
        bus.ram_we  = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        bus.done = id_q ? 2'b10 : 2'b01;
        state_d  = S_IDLE;
      end
      default: begin
        bus.busy   = 1'b0;
        bus.st_out = S_IDLE;
        state_d    = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_job_sched.sv
// Self-checking bench for mult_job_sched: two instances (MUL_LAT 1 and 4)
// checked every cycle against a timeline model plus directed corner cases.
module tb_mult_job_sched;
  import mult_job_sched_pkg::*;

  localparam int AW = 3;
  localparam int OW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_job_sched_if #(.ADDR_W(AW)) bus1 ();
  mult_job_sched_if #(.ADDR_W(AW)) bus4 ();

  mult_job_sched #(.ADDR_W(AW), .MUL_LAT(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1.slave));
  mult_job_sched #(.ADDR_W(AW), .MUL_LAT(4)) dut4 (.clk(clk), .reset(rst), .bus(bus4.slave));

  logic [1:0]      req_v [2];
  logic [2*AW-1:0] sa_v [2];
  logic [2*AW-1:0] sb_v [2];
  logic [2*AW-1:0] d_v [2];

  assign bus1.req   = req_v[0];
  assign bus1.src_a = sa_v[0];
  assign bus1.src_b = sb_v[0];
  assign bus1.dst   = d_v[0];
  assign bus4.req   = req_v[1];
  assign bus4.src_a = sa_v[1];
  assign bus4.src_b = sb_v[1];
  assign bus4.dst   = d_v[1];

  // Packed view: grant[16:15] done[14:13] busy[12] rf[11:9] la[8] lb[7] we[6] ram[5:3] st[2:0]
  wire [OW-1:0] obs0 = {bus1.grant, bus1.done, bus1.busy, bus1.rf_adr, bus1.ld_a,
                        bus1.ld_b, bus1.ram_we, bus1.ram_adr, bus1.st_out};
  wire [OW-1:0] obs1 = {bus4.grant, bus4.done, bus4.busy, bus4.rf_adr, bus4.ld_a,
                        bus4.ld_b, bus4.ram_we, bus4.ram_adr, bus4.st_out};

  int n_chk = 0;
  int n_pass = 0;
  logic [OW-1:0] snap [2];
  logic          tbl_en = 1'b0;
  logic [OW-1:0] tbl_exp;
  string         tbl_nm;

  // Reference model: cycles elapsed since the grant, -1 when idle.
  int             mk [2];
  int             mw [2];
  int             mlast [2];
  int             lat [2];
  logic [AW-1:0]  ma [2];
  logic [AW-1:0]  mb [2];
  logic [AW-1:0]  md [2];

  function automatic logic [OW-1:0] pk(logic [1:0] g, logic [1:0] dn, logic bz,
                                       logic [AW-1:0] rf, logic la, logic lb,
                                       logic we, logic [AW-1:0] ra, logic [2:0] st);
    return {g, dn, bz, rf, la, lb, we, ra, st};
  endfunction

  function automatic logic [1:0] win(int i);
    case (req_v[i])
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return (mlast[i] == 1) ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [OW-1:0] expv(int i);
    logic [1:0] g, dn;
    logic bz, la, lb, we;
    logic [AW-1:0] rf, ra;
    logic [2:0] st;
    int k, L;
    g = '0; dn = '0; bz = 0; la = 0; lb = 0; we = 0; rf = '0; ra = '0; st = '0;
    k = mk[i];
    L = lat[i];
    if (!rst) begin
      if (k < 0) g = win(i);
      else begin
        bz = 1'b1;
        if (k == 1)           begin st = 3'd1; la = 1'b1; rf = ma[i]; end
        else if (k == 2)      begin st = 3'd2; lb = 1'b1; rf = mb[i]; end
        else if (k <= 2 + L)  st = 3'd3;
        else if (k == 3 + L)  begin st = 3'd4; we = 1'b1; ra = md[i]; end
        else                  begin st = 3'd5; dn = (mw[i] == 1) ? 2'b10 : 2'b01; end
      end
    end
    return pk(g, dn, bz, rf, la, lb, we, ra, st);
  endfunction

  task automatic model_edge(int i);
    int w;
    if (rst) begin
      mk[i] = -1;
      mlast[i] = 1;
    end else if (mk[i] < 0) begin
      if (req_v[i] != 2'b00) begin
        w = (win(i) == 2'b10) ? 1 : 0;
        ma[i] = sa_v[i][w*AW +: AW];
        mb[i] = sb_v[i][w*AW +: AW];
        md[i] = d_v[i][w*AW +: AW];
        mw[i] = w;
        mlast[i] = w;
        mk[i] = 1;
      end
    end else begin
      mk[i]++;
      if (mk[i] >= 5 + lat[i]) mk[i] = -1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    snap[0] = obs0;
    snap[1] = obs1;
    chk("model_dut1", 32'(snap[0]), 32'(expv(0)));
    chk("model_dut4", 32'(snap[1]), 32'(expv(1)));
    if (tbl_en) chk(tbl_nm, 32'(snap[0]), 32'(tbl_exp));
    for (int i = 0; i < 2; i++) model_edge(i);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [AW-1:0] sa, sb, d;
    logic [1:0]    g, dn;
    logic          bz;
    logic [AW-1:0] rf;
    logic          la, lb, we;
    logic [AW-1:0] ra;
    logic [2:0]    st;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gc, dc, c, tg, tw, td, nm, nwe, g0;
    int gt [3];
    logic [1:0] gv [3];
    logic [1:0] dv [3];
    logic [1:0] tie_exp [3];
    logic [1:0] dd;
    logic [AW-1:0] wa, la_rf;

    lat[0] = 1;
    lat[1] = 4;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = '0; sa_v[i] = '0; sb_v[i] = '0; d_v[i] = '0;
      mk[i] = -1; mw[i] = 0; mlast[i] = 1;
      ma[i] = '0; mb[i] = '0; md[i] = '0;
    end
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("reset_state_dut1", 32'(obs0), 32'(0));
    chk("reset_state_dut4", 32'(obs1), 32'(0));

    // Single job, MUL_LAT=1, hand-written expectations per cycle
    //          req    sa    sb    d     g      dn     bz  rf    la lb we ra    st
    tbl[0] = '{2'b01, 3'd2, 3'd5, 3'd6, 2'b01, 2'b00, 0, 3'd0, 0, 0, 0, 3'd0, 3'd0};
    tbl[1] = '{2'b00, 3'd2, 3'd5, 3'd6, 2'b00, 2'b00, 1, 3'd2, 1, 0, 0, 3'd0, 3'd1};
    tbl[2] = '{2'b00, 3'd2, 3'd5, 3'd6, 2'b00, 2'b00, 1, 3'd5, 0, 1, 0, 3'd0, 3'd2};
    tbl[3] = '{2'b00, 3'd2, 3'd5, 3'd6, 2'b00, 2'b00, 1, 3'd0, 0, 0, 0, 3'd0, 3'd3};
    tbl[4] = '{2'b00, 3'd2, 3'd5, 3'd6, 2'b00, 2'b00, 1, 3'd0, 0, 0, 1, 3'd6, 3'd4};
    tbl[5] = '{2'b00, 3'd2, 3'd5, 3'd6, 2'b00, 2'b01, 1, 3'd0, 0, 0, 0, 3'd0, 3'd5};
    tbl[6] = '{2'b00, 3'd2, 3'd5, 3'd6, 2'b00, 2'b00, 0, 3'd0, 0, 0, 0, 3'd0, 3'd0};
    for (int r = 0; r < 7; r++) begin
      req_v[0] = tbl[r].req;
      sa_v[0]  = {3'd0, tbl[r].sa};
      sb_v[0]  = {3'd0, tbl[r].sb};
      d_v[0]   = {3'd0, tbl[r].d};
      tbl_exp  = pk(tbl[r].g, tbl[r].dn, tbl[r].bz, tbl[r].rf, tbl[r].la,
                    tbl[r].lb, tbl[r].we, tbl[r].ra, tbl[r].st);
      tbl_nm   = $sformatf("single_job_row%0d", r);
      tbl_en   = 1'b1;
      cyc();
    end
    tbl_en = 1'b0;

    // Tie fairness: both requesting through three jobs
    do_reset();
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
    req_v[0] = 2'b11;
    gc = 0; dc = 0; c = 0;
    while (c < 40 && dc < 3) begin
      cyc();
      if (snap[0][16:15] != 2'b00 && gc < 3) begin gt[gc] = c; gv[gc] = snap[0][16:15]; gc++; end
      if (snap[0][14:13] != 2'b00 && dc < 3) begin dv[dc] = snap[0][14:13]; dc++; end
      c++;
    end
    req_v[0] = 2'b00;
    chk("tie_grant_count", gc, 3);
    chk("tie_done_count", dc, 3);
    for (int i = 0; i < gc; i++) chk($sformatf("tie_grant%0d", i), 32'(gv[i]), 32'(tie_exp[i]));
    for (int i = 1; i < gc; i++) chk($sformatf("tie_interval%0d", i), gt[i] - gt[i-1], 6);
    for (int i = 0; i < dc && i < gc; i++) chk($sformatf("tie_done_id%0d", i), 32'(dv[i]), 32'(gv[i]));

    // MUL_LAT=4, job from requester 1 on the second instance
    req_v[1] = 2'b10;
    sa_v[1] = {3'd1, 3'd0}; sb_v[1] = {3'd4, 3'd0}; d_v[1] = {3'd7, 3'd0};
    tg = -100; tw = -100; td = -100; nm = 0; wa = '0; dd = '0; c = 0;
    while (c < 30 && td < 0) begin
      cyc();
      if (snap[1][16:15] != 2'b00) begin tg = c; dd = snap[1][16:15]; req_v[1] = 2'b00; end
      if (snap[1][2:0] == 3'd3) nm++;
      if (snap[1][6]) begin tw = c; wa = snap[1][5:3]; end
      if (snap[1][14:13] != 2'b00) begin td = c; dd = snap[1][14:13]; end
      c++;
    end
    req_v[1] = 2'b00;
    chk("lat4_mult_cycles", nm, 4);
    chk("lat4_we_offset", tw - tg, 7);
    chk("lat4_ram_adr", 32'(wa), 32'(7));
    chk("lat4_done_offset", td - tg, 8);
    chk("lat4_done_id", 32'(dd), 32'(2'b10));

    // Field freeze: dst changes right after grant
    req_v[0] = 2'b01;
    sa_v[0] = {3'd0, 3'd1}; sb_v[0] = {3'd0, 3'd2}; d_v[0] = {3'd0, 3'd3};
    cyc();
    chk("freeze_grant", 32'(snap[0][16:15]), 32'(2'b01));
    req_v[0] = 2'b00;
    sa_v[0] = {3'd0, 3'd6}; sb_v[0] = {3'd0, 3'd6}; d_v[0] = {3'd0, 3'd7};
    wa = '1; la_rf = '1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (snap[0][8]) la_rf = snap[0][11:9];
      if (snap[0][6]) wa = snap[0][5:3];
    end
    chk("freeze_rf_adr_a", 32'(la_rf), 32'(1));
    chk("freeze_ram_adr", 32'(wa), 32'(3));

    // Reset asserted during MULT
    req_v[0] = 2'b01;
    cyc();
    req_v[0] = 2'b00;
    cyc();
    cyc();
    chk("rst_pre_in_mult", 32'(obs0[2:0]), 32'(3));
    req_v[0] = 2'b11;
    req_v[1] = 2'b11;
    rst = 1'b1;
    #1;
    chk("rst_async_dut1", 32'(obs0), 32'(0));
    chk("rst_async_dut4", 32'(obs1), 32'(0));
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_release_grant_dut1", 32'(snap[0][16:15]), 32'(2'b01));
    chk("rst_release_grant_dut4", 32'(snap[1][16:15]), 32'(2'b01));
    req_v[0] = 2'b00;
    req_v[1] = 2'b00;
    repeat (12) cyc();

    // Dropped request: req0 pulses only during LOAD_B of a requester-1 job
    req_v[0] = 2'b10;
    cyc();
    req_v[0] = 2'b00;
    cyc();
    req_v[0] = 2'b01;
    cyc();
    chk("drop_in_load_b", 32'(snap[0][2:0]), 32'(2));
    req_v[0] = 2'b00;
    g0 = 0; nwe = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (snap[0][15]) g0++;
      if (snap[0][6]) nwe++;
    end
    chk("drop_no_grant0", g0, 0);
    chk("drop_we_count", nwe, 1);

    // Randomized traffic, occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        c = $urandom_range(0, 9);
        req_v[i] = (c < 4) ? 2'b00 : (c < 6) ? 2'b01 : (c < 8) ? 2'b10 : 2'b11;
        sa_v[i] = (2*AW)'($urandom);
        sb_v[i] = (2*AW)'($urandom);
        d_v[i]  = (2*AW)'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    req_v[0] = 2'b00;
    req_v[1] = 2'b00;
    repeat (12) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
